// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, client indices, watchdog sizing.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int CLI_PARSE = 0;
  localparam int CLI_GEN   = 1;
  localparam int CLI_DISP  = 2;
  localparam int CLI_CALC  = 3;

  localparam int TIMEOUT_DEF = 25_000_000;
  localparam int WD_W        = 25;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client/UART side signal bundle of the arbiter; master is the arbiter, slave the clients + UART.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int OWNW = 2
);
  logic [NREQ-1:0]   req_pulse;
  logic [NREQ-1:0]   cancel;
  logic [NREQ-1:0]   grant_start;
  logic [NREQ-1:0]   src_tx_start;
  logic [NREQ*8-1:0] src_tx_data;
  logic [NREQ-1:0]   src_done;
  logic [NREQ-1:0]   src_tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              active;
  logic [OWNW-1:0]   owner;
  logic [NREQ-1:0]   pending;
  logic              timeout_err;

  modport master (
    input  req_pulse, cancel, src_tx_start, src_tx_data, src_done, tx_busy,
    output grant_start, src_tx_busy, tx_start, tx_data, active, owner, pending, timeout_err
  );

  modport slave (
    output req_pulse, cancel, src_tx_start, src_tx_data, src_done, tx_busy,
    input  grant_start, src_tx_busy, tx_start, tx_data, active, owner, pending, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request bit after last_i, wrapping at NREQ.
module uart_tx_arbiter_rr_picker #(
  parameter int NREQ = 4,
  parameter int OWNW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [OWNW-1:0] last_i,
  output logic            found_o,
  output logic [OWNW-1:0] idx_o
);

  int cand;

  // Scan farthest candidate first so the nearest one after last_i overwrites it.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(last_i) + k) % NREQ;
      if (req_i[OWNW'(cand)]) begin
        found_o = 1'b1;
        idx_o   = OWNW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NREQ printer clients: queued one-cycle requests, round-robin grant,
// owner's tx_start/tx_data forwarded until done, cancel or watchdog expiry, then drain the byte in flight.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int OWNW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [OWNW-1:0] owner_q, owner_d;
  logic [OWNW-1:0] last_owner_q, last_owner_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  logic            pick_found;
  logic [OWNW-1:0] pick_idx;
  logic            ev_done, ev_cancel, ev_timeout;

  uart_tx_arbiter_rr_picker #(
    .NREQ (NREQ),
    .OWNW (OWNW)
  ) u_picker (
    .req_i   (pending_q),
    .last_i  (last_owner_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign ev_done    = bus.src_done[owner_q];
  assign ev_cancel  = bus.cancel[owner_q];
  assign ev_timeout = (wdog_q == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_found) state_d = ST_START;
      ST_START: state_d = ST_BUSY;
      ST_BUSY:  if (ev_done || ev_cancel || ev_timeout) state_d = ST_DRAIN;
      ST_DRAIN: if (!bus.tx_busy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.tx_start    = 1'b0;
    bus.tx_data     = '0;
    bus.src_tx_busy = '1;
    bus.timeout_err = 1'b0;
    if (state_q == ST_BUSY) begin
      // An abort suppresses the owner's start in the very cycle it is raised.
      bus.tx_start             = bus.src_tx_start[owner_q] & ~ev_cancel;
      bus.tx_data              = bus.src_tx_data[{owner_q, 3'b000} +: 8];
      bus.src_tx_busy[owner_q] = bus.tx_busy;
      bus.timeout_err          = ev_timeout & ~ev_done & ~ev_cancel;
    end
  end

  assign bus.grant_start = grant_q;
  assign bus.active      = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
  assign bus.owner       = owner_q;
  assign bus.pending     = pending_q;

  // Cancel beats a same-cycle request; a request from the current owner re-queues it.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      if (bus.cancel[i]) begin
        pending_d[i] = 1'b0;
      end else if (bus.req_pulse[i]) begin
        pending_d[i] = 1'b1;
      end else if (state_q == ST_START && owner_q == OWNW'(i)) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  always_comb begin
    grant_d      = '0;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wdog_d       = wdog_q;
    if (state_q == ST_IDLE && pick_found) begin
      grant_d[pick_idx] = 1'b1;
      owner_d           = pick_idx;
    end
    if (state_q == ST_START) begin
      wdog_d = '0;
    end else if (state_q == ST_BUSY && wdog_q != '1) begin
      wdog_d = wdog_q + 1'b1;
    end
    if (state_q == ST_DRAIN && !bus.tx_busy) begin
      last_owner_d = owner_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= OWNW'(NREQ - 1);
      wdog_q       <= '0;
    end else begin
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wdog_q       <= wdog_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter: stimulus queues expected grants/bytes/timeouts, a monitor pops them.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int OWNW = 2;
  localparam int TOUT = 100;
  localparam int WAIT_MAX = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   mon_g;
  int   mon_t;
  logic [7:0] mon_b;

  int         exp_grant[$];
  logic [7:0] exp_byte[$];
  int         exp_to[$];

  uart_tx_arbiter_if #(.NREQ(NREQ), .OWNW(OWNW)) bus();

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TOUT), .OWNW(OWNW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // UART model: accepts a start when idle, stays busy for 4 cycles.
  always @(negedge clk) begin
    if (!rst_n) busy_cnt = 0;
    else if (bus.tx_start && busy_cnt == 0) busy_cnt = 4;
    else if (busy_cnt != 0) busy_cnt--;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.grant_start != '0) begin
        if (exp_grant.size() == 0) chk("grant_unexpected", 64'(bus.grant_start), 64'd0);
        else begin
          mon_g = exp_grant.pop_front();
          chk("grant_vector", 64'(bus.grant_start), 64'(1 << mon_g));
        end
      end
      if (bus.tx_start) begin
        if (exp_byte.size() == 0) chk("tx_unexpected", 64'(bus.tx_data), 64'hFFFF);
        else begin
          mon_b = exp_byte.pop_front();
          chk("tx_data", 64'(bus.tx_data), 64'(mon_b));
        end
      end
      if (bus.timeout_err) begin
        if (exp_to.size() == 0) chk("timeout_unexpected", 64'(cyc), 64'd0);
        else begin
          mon_t = exp_to.pop_front();
          chk("timeout_cycle", 64'(cyc), 64'(mon_t));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [NREQ-1:0] v);
    bus.req_pulse = v;
    tick();
    bus.req_pulse = '0;
  endtask

  task automatic wait_grant(input int i, output int gcyc);
    int n;
    n = 0;
    while (bus.grant_start[i] !== 1'b1 && n < WAIT_MAX) begin
      tick();
      n++;
    end
    if (n >= WAIT_MAX) chk("grant_wait_expired", 64'(i), 64'hDEAD);
    else chk("grant_after_txbusy_low", 64'(bus.tx_busy), 64'd0);
    gcyc = cyc;
  endtask

  task automatic send_byte(input int i, input logic [7:0] d);
    int n;
    n = 0;
    while (bus.src_tx_busy[i] && n < WAIT_MAX) begin
      tick();
      n++;
    end
    if (n >= WAIT_MAX) chk("busy_wait_expired", 64'(i), 64'hDEAD);
    exp_byte.push_back(d);
    bus.src_tx_start[i]        = 1'b1;
    bus.src_tx_data[i*8 +: 8]  = d;
    tick();
    bus.src_tx_start[i] = 1'b0;
  endtask

  task automatic pulse_done(input int i);
    bus.src_done[i] = 1'b1;
    tick();
    bus.src_done[i] = 1'b0;
  endtask

  task automatic serve(input int i, input logic [7:0] b0, input logic [7:0] b1);
    send_byte(i, b0);
    send_byte(i, b1);
    pulse_done(i);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.active && n < WAIT_MAX) begin
      tick();
      n++;
    end
    if (n >= WAIT_MAX) chk("idle_wait_expired", 64'(bus.owner), 64'hDEAD);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int t;
    int g;
    bus.req_pulse    = '0;
    bus.cancel       = '0;
    bus.src_tx_start = '0;
    bus.src_tx_data  = '0;
    bus.src_done     = '0;

    // Reset values
    tick();
    tick();
    chk("rst_grant", 64'(bus.grant_start), 64'd0);
    chk("rst_tx_start", 64'(bus.tx_start), 64'd0);
    chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
    chk("rst_pending", 64'(bus.pending), 64'd0);
    chk("rst_active", 64'(bus.active), 64'd0);
    chk("rst_owner", 64'(bus.owner), 64'd0);
    chk("rst_timeout", 64'(bus.timeout_err), 64'd0);
    chk("rst_src_busy", 64'(bus.src_tx_busy), 64'hF);
    rst_n = 1'b1;
    tick();

    // 1. Single request, latency t+2
    t = cyc;
    exp_grant.push_back(CLI_GEN);
    pulse_req(4'b0010);
    chk("t1_pending_set", 64'(bus.pending), 64'b0010);
    wait_grant(CLI_GEN, g);
    chk("t1_latency", 64'(g - t), 64'd2);
    serve(CLI_GEN, 8'h31, 8'h0D);
    wait_idle();
    chk("t1_pending_clear", 64'(bus.pending), 64'd0);
    chk("t1_owner", 64'(bus.owner), 64'(CLI_GEN));

    // 2. Simultaneous requests from reset: order 0,1,3
    do_reset();
    exp_grant.push_back(CLI_PARSE);
    exp_grant.push_back(CLI_GEN);
    exp_grant.push_back(CLI_CALC);
    pulse_req(4'b1011);
    wait_grant(CLI_PARSE, g);
    serve(CLI_PARSE, 8'h10, 8'h11);
    wait_grant(CLI_GEN, g);
    serve(CLI_GEN, 8'h20, 8'h21);
    wait_grant(CLI_CALC, g);
    serve(CLI_CALC, 8'h30, 8'h31);
    wait_idle();
    chk("t2_pending_clear", 64'(bus.pending), 64'd0);

    // 3. Fairness: 0 re-requests while 2 waits -> 2 goes before 0
    exp_grant.push_back(CLI_PARSE);
    pulse_req(4'b0001);
    wait_grant(CLI_PARSE, g);
    send_byte(CLI_PARSE, 8'h50);
    exp_grant.push_back(CLI_DISP);
    exp_grant.push_back(CLI_PARSE);
    pulse_req(4'b0101);
    chk("t3_pending_both", 64'(bus.pending), 64'b0101);
    send_byte(CLI_PARSE, 8'h51);
    pulse_done(CLI_PARSE);
    wait_grant(CLI_DISP, g);
    serve(CLI_DISP, 8'h60, 8'h61);
    wait_grant(CLI_PARSE, g);
    serve(CLI_PARSE, 8'h52, 8'h53);
    wait_idle();

    // 4. Cancel pending and cancel active
    exp_grant.push_back(CLI_GEN);
    pulse_req(4'b0010);
    wait_grant(CLI_GEN, g);
    tick();
    pulse_req(4'b0100);
    chk("t4_pending2_set", 64'(bus.pending), 64'b0100);
    bus.cancel = 4'b0100;
    tick();
    bus.cancel = '0;
    chk("t4_pending2_cancel", 64'(bus.pending), 64'd0);
    send_byte(CLI_GEN, 8'h41);
    bus.cancel[CLI_GEN]             = 1'b1;
    bus.src_tx_start[CLI_GEN]       = 1'b1;
    bus.src_tx_data[CLI_GEN*8 +: 8] = 8'h42;
    #1;
    chk("t4_cancel_tx_start", 64'(bus.tx_start), 64'd0);
    tick();
    bus.cancel       = '0;
    bus.src_tx_start = '0;
    chk("t4_drain_active", 64'(bus.active), 64'd1);
    chk("t4_drain_tx_start", 64'(bus.tx_start), 64'd0);
    wait_idle();
    chk("t4_idle_txbusy", 64'(bus.tx_busy), 64'd0);
    bus.req_pulse = 4'b1000;
    bus.cancel    = 4'b1000;
    tick();
    bus.req_pulse = '0;
    bus.cancel    = '0;
    chk("t4_req_cancel_same", 64'(bus.pending), 64'd0);
    bus.src_tx_start = 4'b1111;
    bus.src_tx_data  = 32'hA5A5_A5A5;
    #1;
    chk("t4_stray_tx_start", 64'(bus.tx_start), 64'd0);
    chk("t4_stray_tx_data", 64'(bus.tx_data), 64'd0);
    bus.src_tx_start = '0;
    repeat (4) tick();

    // 5. Watchdog: client 3 never finishes, then pending client 0 is served
    exp_grant.push_back(CLI_CALC);
    exp_grant.push_back(CLI_PARSE);
    pulse_req(4'b1001);
    wait_grant(CLI_CALC, g);
    exp_to.push_back(g + TOUT);
    tick();
    pulse_done(CLI_PARSE);
    chk("t5_nonowner_done", 64'(bus.active), 64'd1);
    wait_grant(CLI_PARSE, g);
    serve(CLI_PARSE, 8'h70, 8'h71);
    wait_idle();

    // 6. Reset in BUSY mid-byte
    exp_grant.push_back(CLI_GEN);
    pulse_req(4'b0010);
    wait_grant(CLI_GEN, g);
    send_byte(CLI_GEN, 8'h81);
    pulse_req(4'b0100);
    bus.src_tx_start[CLI_GEN] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_grant", 64'(bus.grant_start), 64'd0);
    chk("t6_tx_start", 64'(bus.tx_start), 64'd0);
    chk("t6_tx_data", 64'(bus.tx_data), 64'd0);
    chk("t6_pending", 64'(bus.pending), 64'd0);
    chk("t6_active", 64'(bus.active), 64'd0);
    chk("t6_owner", 64'(bus.owner), 64'd0);
    chk("t6_src_busy", 64'(bus.src_tx_busy), 64'hF);
    bus.src_tx_start = '0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t6_no_retained_pending", 64'(bus.pending), 64'd0);
    chk("t6_no_regrant", 64'(bus.active), 64'd0);

    chk("left_grants", 64'(exp_grant.size()), 64'd0);
    chk("left_bytes", 64'(exp_byte.size()), 64'd0);
    chk("left_timeouts", 64'(exp_to.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
